// File: rtl/led_fade_driver.sv
// Eight-LED fading driver: lit LEDs go to full brightness, unlit LEDs step down
// one level every DECAY_PERIODS PWM periods, and each level is rendered as PWM duty.
module led_fade_driver #(
    parameter int PWM_BITS      = 4,
    parameter int DECAY_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pat_valid,
    input  logic [7:0] pat_in,
    output logic [7:0] led_out,
    output logic       decay_tick
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [7:0]          PER_LAST = 8'(DECAY_PERIODS - 1);

    logic [7:0]                r_pat;
    logic [7:0][PWM_BITS-1:0]  r_level;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic [7:0]                r_per_cnt;

    logic                      w_period_end;
    logic                      w_decay;
    logic [7:0]                w_eff;
    logic [7:0][PWM_BITS-1:0]  w_level_nxt;
    logic [7:0]                w_led_nxt;

    assign w_period_end = (r_pwm_cnt == LVL_MAX);
    assign w_decay      = w_period_end && (r_per_cnt == PER_LAST);
    // A pattern arriving this cycle overrides the stored one, so a load that
    // coincides with a decay step lets newly cleared LEDs decay on that edge.
    assign w_eff        = pat_valid ? pat_in : r_pat;

    always_comb begin
        w_level_nxt = r_level;
        w_led_nxt   = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_eff[i])
                w_level_nxt[i] = LVL_MAX;
            else if (w_decay && (r_level[i] != '0))
                w_level_nxt[i] = r_level[i] - 1'b1;
            w_led_nxt[i] = (r_level[i] > r_pwm_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat      <= '0;
            r_level    <= '0;
            r_pwm_cnt  <= '0;
            r_per_cnt  <= '0;
            led_out    <= '0;
            decay_tick <= 1'b0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            if (w_period_end)
                r_per_cnt <= (r_per_cnt == PER_LAST) ? 8'd0 : r_per_cnt + 8'd1;
            if (pat_valid)
                r_pat <= pat_in;
            r_level    <= w_level_nxt;
            led_out    <= w_led_nxt;
            decay_tick <= w_decay;
        end
    end

endmodule
